// File: rtl/hydra_pkg.sv
// Shared constants and enums for the port read-side SRAM matcher.
package hydra_pkg;

    localparam int SRAM_NUM   = 32;
    localparam int SRAM_IDX_W = 5;
    localparam int AMOUNT_W   = 9;

    typedef enum logic [1:0] {
        MATCH_FIRST  = 2'd0,
        MATCH_MAX    = 2'd1,
        MATCH_THRESH = 2'd2
    } match_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } match_state_e;

endpackage

// File: rtl/port_rd_sram_matcher.sv
// Scans all SRAMs for queued packets of this port and reports the best one.
// Optional RD_MATCH_FAIR_START_EN rotates the scan start past the last winner.
module port_rd_sram_matcher #(
    parameter int SRAM_NUM = hydra_pkg::SRAM_NUM,
    parameter int AMOUNT_W = hydra_pkg::AMOUNT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       match_mode,
    input  logic [4:0]                       match_threshold,
    input  logic                             match_enable,
    input  logic [AMOUNT_W-1:0]              packet_amount,
    input  logic                             accessible,
    output logic [hydra_pkg::SRAM_IDX_W-1:0] matching_next_sram,
    output logic [hydra_pkg::SRAM_IDX_W-1:0] matching_best_sram,
    output logic                             match_end,
    output logic                             match_found
);
    import hydra_pkg::*;

    localparam int CNT_W = $clog2(SRAM_NUM + 1);
    localparam logic [CNT_W-1:0] SRAM_CNT = CNT_W'(SRAM_NUM);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SRAM_NUM - 1);

    match_state_e            state_reg, state_next;
    logic [SRAM_IDX_W-1:0]   start_ptr_reg;
    logic [SRAM_IDX_W-1:0]   scan_ptr_reg;
    logic [SRAM_IDX_W-1:0]   prev_idx_reg;
    logic                    prev_valid_reg;
    logic [CNT_W-1:0]        issue_cnt_reg;
    logic [CNT_W-1:0]        eval_cnt_reg;
    logic [1:0]              mode_reg;
    logic [AMOUNT_W-1:0]     thresh_reg;
    logic [SRAM_IDX_W-1:0]   best_idx_reg;
    logic [AMOUNT_W-1:0]     best_amt_reg;
    logic                    found_reg;

    logic cand;
    logic is_first;
    logic stop_hit;
    logic better;
    logic last_eval;

    // Evaluation of the index presented one cycle earlier.
    always_comb begin
        cand      = accessible && (packet_amount != '0);
        is_first  = (mode_reg == MATCH_FIRST) || (mode_reg == 2'd3);
        stop_hit  = 1'b0;
        better    = 1'b0;
        if (prev_valid_reg && cand) begin
            if (is_first) begin
                stop_hit = 1'b1;
            end else if ((mode_reg == MATCH_THRESH) && (packet_amount >= thresh_reg)) begin
                stop_hit = 1'b1;
            end else if (packet_amount > best_amt_reg) begin
                better = 1'b1;
            end
        end
        last_eval = prev_valid_reg && (eval_cnt_reg == LAST_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (match_enable) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (!match_enable)             state_next = ST_IDLE;
                else if (stop_hit || last_eval) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        match_end          = (state_reg == ST_DONE);
        match_found        = (state_reg == ST_DONE) && found_reg;
        matching_next_sram = (state_reg == ST_IDLE) ? start_ptr_reg : scan_ptr_reg;
        matching_best_sram = best_idx_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_ptr_reg  <= '0;
            scan_ptr_reg   <= '0;
            prev_idx_reg   <= '0;
            prev_valid_reg <= 1'b0;
            issue_cnt_reg  <= '0;
            eval_cnt_reg   <= '0;
            mode_reg       <= 2'd0;
            thresh_reg     <= '0;
            best_idx_reg   <= '0;
            best_amt_reg   <= '0;
            found_reg      <= 1'b0;
        end else begin
            prev_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (match_enable) begin
                        scan_ptr_reg  <= start_ptr_reg;
                        issue_cnt_reg <= '0;
                        eval_cnt_reg  <= '0;
                        mode_reg      <= match_mode;
                        thresh_reg    <= AMOUNT_W'(match_threshold);
                        best_idx_reg  <= '0;
                        best_amt_reg  <= '0;
                        found_reg     <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (!match_enable) begin
                        best_idx_reg <= '0;
                        best_amt_reg <= '0;
                        found_reg    <= 1'b0;
                    end else begin
                        // The pointer parks on the last index so the final cycle
                        // only evaluates and issues nothing new.
                        if (issue_cnt_reg < SRAM_CNT) begin
                            issue_cnt_reg  <= issue_cnt_reg + 1'b1;
                            prev_valid_reg <= 1'b1;
                            prev_idx_reg   <= scan_ptr_reg;
                            if (issue_cnt_reg != LAST_CNT) begin
                                scan_ptr_reg <= scan_ptr_reg + 1'b1;
                            end
                        end
                        if (prev_valid_reg) begin
                            eval_cnt_reg <= eval_cnt_reg + 1'b1;
                        end
                        if (stop_hit || better) begin
                            best_idx_reg <= prev_idx_reg;
                            best_amt_reg <= packet_amount;
                            found_reg    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
`ifdef RD_MATCH_FAIR_START_EN
                    if (found_reg) begin
                        start_ptr_reg <= best_idx_reg + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_port_rd_sram_matcher.sv
// Randomized and directed bench for port_rd_sram_matcher with an order-based reference model.
module tb_port_rd_sram_matcher;
    localparam int N = 32;
`ifdef RD_MATCH_FAIR_START_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] match_mode;
    logic [4:0] match_threshold;
    logic       match_enable;
    logic [8:0] packet_amount = '0;
    logic       accessible = 1'b0;
    logic [4:0] matching_next_sram;
    logic [4:0] matching_best_sram;
    logic       match_end;
    logic       match_found;

    logic [8:0] mem_amt [N];
    logic       mem_acc [N];

    int tests_run = 0;
    int tests_failed = 0;
    int model_start = 0;

    always #5 clk = ~clk;

    port_rd_sram_matcher dut (
        .clk                (clk),
        .rst                (rst),
        .match_mode         (match_mode),
        .match_threshold    (match_threshold),
        .match_enable       (match_enable),
        .packet_amount      (packet_amount),
        .accessible         (accessible),
        .matching_next_sram (matching_next_sram),
        .matching_best_sram (matching_best_sram),
        .match_end          (match_end),
        .match_found        (match_found)
    );

    // External status mux: answers for the index presented in the previous cycle.
    always @(posedge clk) begin
        packet_amount <= mem_amt[matching_next_sram];
        accessible    <= mem_acc[matching_next_sram];
    end

    // Reference: walk the SRAMs in scan order from the start pointer.
    // steps = number of evaluations performed; match_end lands at cycle steps+2.
    function automatic void ref_match(input int start, input int mode, input int thr,
                                      output int best, output int found, output int steps);
        int bamt;
        best = 0; found = 0; bamt = 0; steps = N;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (mem_acc[idx] && mem_amt[idx] != 0) begin
                if (mode == 0 || mode == 3 || (mode == 2 && int'(mem_amt[idx]) >= thr)) begin
                    best = idx; found = 1; steps = k + 1;
                    break;
                end else if (int'(mem_amt[idx]) > bamt) begin
                    best = idx; found = 1; bamt = int'(mem_amt[idx]);
                end
            end
        end
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < N; i++) begin
            mem_amt[i] = '0;
            mem_acc[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        match_enable = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_start = 0;
        @(posedge clk); #1;
    endtask

    // Called at cycle 0 (1 time unit after an edge, FSM idle). Enable is raised
    // now; the cycle of the first match_end pulse is reported (-1 if none).
    task automatic run_match(input logic [1:0] mode, input logic [4:0] thr, input bit drop_after,
                             output int end_cyc, output int best, output int found);
        match_mode = mode;
        match_threshold = thr;
        match_enable = 1'b1;
        end_cyc = -1; best = 0; found = 0;
        for (int c = 1; c <= 60 && end_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (match_end === 1'b1) begin
                end_cyc = c;
                best = int'(matching_best_sram);
                found = int'(match_found);
            end
        end
        $display("[TB] match mode=%0d thr=%0d end_cycle=%0d best=%0d found=%0d",
                 mode, thr, end_cyc, best, found);
        if (drop_after) begin
            match_enable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        match_enable = 1'b0; match_mode = 2'd0; match_threshold = 5'd0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (matching_next_sram !== 5'd0) begin tests_failed++; $display("FAIL reset_next got %0d want 0", matching_next_sram); end
        tests_run++;
        if (matching_best_sram !== 5'd0) begin tests_failed++; $display("FAIL reset_best got %0d want 0", matching_best_sram); end
        tests_run++;
        if (match_end !== 1'b0) begin tests_failed++; $display("FAIL reset_end got %b want 0", match_end); end
        tests_run++;
        if (match_found !== 1'b0) begin tests_failed++; $display("FAIL reset_found got %b want 0", match_found); end
        rst = 1'b0;
        model_start = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_first_hit();
        int e, b, f;
        do_reset();
        clear_mem();
        mem_acc[0] = 1'b1; mem_amt[0] = 9'd5;
        run_match(2'd0, 5'd0, 1'b1, e, b, f);
        tests_run++;
        if (e !== 3) begin tests_failed++; $display("FAIL first_end_cycle got %0d want 3", e); end
        tests_run++;
        if (b !== 0) begin tests_failed++; $display("FAIL first_best got %0d want 0", b); end
        tests_run++;
        if (f !== 1) begin tests_failed++; $display("FAIL first_found got %0d want 1", f); end
    endtask

    task automatic test_max();
        int e, b, f;
        do_reset();
        clear_mem();
        for (int i = 0; i < N; i++) mem_acc[i] = 1'b1;
        mem_amt[4] = 9'd3; mem_amt[17] = 9'd9; mem_amt[20] = 9'd9;
        run_match(2'd1, 5'd0, 1'b1, e, b, f);
        tests_run++;
        if (e !== 34) begin tests_failed++; $display("FAIL max_end_cycle got %0d want 34", e); end
        tests_run++;
        if (b !== 17) begin tests_failed++; $display("FAIL max_best_tie got %0d want 17", b); end
        tests_run++;
        if (f !== 1) begin tests_failed++; $display("FAIL max_found got %0d want 1", f); end
    endtask

    task automatic test_thresh();
        int e, b, f;
        do_reset();
        clear_mem();
        for (int i = 0; i < N; i++) mem_acc[i] = 1'b1;
        mem_amt[1] = 9'd2; mem_amt[10] = 9'd7; mem_amt[20] = 9'd30;
        run_match(2'd2, 5'd6, 1'b1, e, b, f);
        // Index 10 is the 11th evaluation: early stop closes at cycle 13.
        tests_run++;
        if (e !== 13) begin tests_failed++; $display("FAIL thresh_end_cycle got %0d want 13", e); end
        tests_run++;
        if (b !== 10) begin tests_failed++; $display("FAIL thresh_best got %0d want 10", b); end
    endtask

    task automatic test_none();
        int e, b, f;
        do_reset();
        clear_mem();
        for (int i = 0; i < N; i++) mem_amt[i] = 9'd50;
        run_match(2'd1, 5'd0, 1'b1, e, b, f);
        tests_run++;
        if (e !== 34) begin tests_failed++; $display("FAIL none_end_cycle got %0d want 34", e); end
        tests_run++;
        if (f !== 0) begin tests_failed++; $display("FAIL none_found got %0d want 0", f); end
        tests_run++;
        if (b !== 0) begin tests_failed++; $display("FAIL none_best got %0d want 0", b); end
    endtask

    task automatic test_random();
        int e, b, f, rb, rf, rs, mode, thr;
        do_reset();
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                mem_acc[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0) mem_amt[i] = 9'(($urandom_range(0, 9) == 0) ? $urandom_range(100, 511) : $urandom_range(1, 12));
                else mem_amt[i] = '0;
            end
            mode = int'($urandom_range(0, 3));
            thr = int'($urandom_range(0, 15));
            ref_match(model_start, mode, thr, rb, rf, rs);
            run_match(2'(mode), 5'(thr), 1'b1, e, b, f);
            tests_run++;
            if (e !== rs + 2) begin tests_failed++; $display("FAIL rand%0d_end_cycle got %0d want %0d", t, e, rs + 2); end
            tests_run++;
            if (f !== rf) begin tests_failed++; $display("FAIL rand%0d_found got %0d want %0d", t, f, rf); end
            if (rf == 1) begin
                tests_run++;
                if (b !== rb) begin tests_failed++; $display("FAIL rand%0d_best got %0d want %0d", t, b, rb); end
            end
            if (FAIR && rf == 1) model_start = (rb + 1) % N;
            tests_run++;
            if (int'(matching_next_sram) !== model_start) begin
                tests_failed++; $display("FAIL rand%0d_idle_start got %0d want %0d", t, matching_next_sram, model_start);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e1, b1, f1, e2, b2, f2, want2;
        do_reset();
        for (int i = 0; i < N; i++) begin
            mem_acc[i] = 1'b1; mem_amt[i] = 9'd1;
        end
        run_match(2'd0, 5'd0, 1'b0, e1, b1, f1);
        tests_run++;
        if (b1 !== 0) begin tests_failed++; $display("FAIL b2b_first_best got %0d want 0", b1); end
        want2 = FAIR ? 1 : 0;
        // Enable stays high: the cycle after DONE is idle and restarts the scan.
        @(posedge clk); #1;
        tests_run++;
        if (int'(matching_next_sram) !== want2) begin tests_failed++; $display("FAIL b2b_idle_start got %0d want %0d", matching_next_sram, want2); end
        run_match(2'd0, 5'd0, 1'b1, e2, b2, f2);
        tests_run++;
        if (b2 !== want2) begin tests_failed++; $display("FAIL b2b_second_best got %0d want %0d", b2, want2); end
        tests_run++;
        if (e2 !== 3) begin tests_failed++; $display("FAIL b2b_second_end_cycle got %0d want 3", e2); end
        tests_run++;
        if (f2 !== 1) begin tests_failed++; $display("FAIL b2b_second_found got %0d want 1", f2); end
    endtask

    task automatic test_abort();
        int pulses;
        // Reset in the middle of a scan.
        do_reset();
        clear_mem();
        for (int i = 0; i < N; i++) begin
            mem_acc[i] = 1'b1; mem_amt[i] = 9'(i + 1);
        end
        match_mode = 2'd1; match_threshold = 5'd0; match_enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({matching_next_sram, matching_best_sram, match_end, match_found} !== 12'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_scan got next=%0d best=%0d end=%b found=%b want all 0",
                     matching_next_sram, matching_best_sram, match_end, match_found);
        end
        match_enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_start = 0;
        @(posedge clk); #1;
        $display("[TB] reset abort at cycle 10 done");
        // Enable dropped in the middle of a scan.
        match_enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        match_enable = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (match_end === 1'b1) pulses++;
        end
        $display("[TB] enable abort at cycle 10 done");
        tests_run++;
        if (pulses !== 0) begin tests_failed++; $display("FAIL en_drop_pulses got %0d want 0", pulses); end
        tests_run++;
        if (matching_best_sram !== 5'd0) begin tests_failed++; $display("FAIL en_drop_best got %0d want 0", matching_best_sram); end
        tests_run++;
        if (int'(matching_next_sram) !== model_start) begin tests_failed++; $display("FAIL en_drop_start got %0d want %0d", matching_next_sram, model_start); end
    endtask

    initial begin
        test_reset();
        test_first_hit();
        test_max();
        test_thresh();
        test_none();
        test_random();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
